// File: rtl/probabilistic_search_sequencer.sv
// Proposal sequencer for the MCMC solver's probabilistic-search step: walks one
// boolean, continuous or discrete variable through its proposal units via handshakes.
module probabilistic_search_sequencer #(
    parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX = 3,
    parameter int TIMEOUT_CYCLES                 = 16,
    parameter int COUNT_WIDTH                    = 16,
    localparam int N_REDUCE                      = 2 ** MAX_BIT_WIDTH_OF_CLAUSES_INDEX
) (
    input  logic                   in_clk,
    input  logic                   in_reset,
    input  logic                   in_start,
    input  logic                   in_abort,
    input  logic [1:0]             in_choosen_variable_type,
    input  logic [N_REDUCE-1:0]    in_active_modules,
    input  logic [N_REDUCE-1:0]    in_reduce_done,
    input  logic                   in_segment_done,
    input  logic                   in_sampler_done,
    input  logic                   in_discrete_size_valid,
    input  logic                   in_discrete_value_valid,
    input  logic                   in_check_done,
    input  logic                   in_need_sample,
    output logic [3:0]             out_state,
    output logic                   out_busy,
    output logic                   out_boolean_propose_enable,
    output logic                   out_select_segment_enable,
    output logic                   out_DiscreteVariablesSizes_enable,
    output logic                   out_random_enable,
    output logic                   out_DiscreteValuesTable_enable,
    output logic                   out_sampler_enable,
    output logic                   out_compute_for_proposed_value,
    output logic                   out_calculate_probability_enable,
    output logic                   out_catch_U,
    output logic [N_REDUCE-1:0]    out_reduce_enable,
    output logic                   out_chosen_variable_is_discrete,
    output logic                   out_done,
    output logic                   out_error,
    output logic [1:0]             out_error_code,
    output logic [3:0]             out_error_state,
    output logic [COUNT_WIDTH-1:0] out_proposal_count
);

    typedef enum logic [3:0] {
        S_IDLE           = 4'd0,
        S_BOOL_PROPOSE   = 4'd1,
        S_REDUCE         = 4'd2,
        S_SELECT_SEGMENT = 4'd3,
        S_SAMPLE         = 4'd4,
        S_GET_SIZE       = 4'd5,
        S_CHOOSE_VALUE   = 4'd6,
        S_READ_VALUE     = 4'd7,
        S_CHECK          = 4'd8,
        S_CALC_PROB      = 4'd9,
        S_ERROR          = 4'd10
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [1:0]              type_q, type_d;
    logic [N_REDUCE-1:0]     pending_q, pending_d;
    logic [N_REDUCE-1:0]     reduce_left_s;
    logic [7:0]              cnt_q, cnt_d;
    logic                    timeout_s;
    logic [1:0]              err_code_q, err_code_d;
    logic [3:0]              err_state_q, err_state_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;

    logic                    bool_en_q, seg_en_q, size_en_q, rand_en_q, table_en_q;
    logic                    samp_en_q, comp_en_q, calc_en_q, catch_q, disc_q;
    logic                    done_q, error_q;
    logic [N_REDUCE-1:0]     red_en_q;

    assign reduce_left_s = pending_q & ~in_reduce_done;
    assign timeout_s     = (cnt_q == TMO_LAST);

    // Next-state, latched-request, error bookkeeping and proposal counter logic.
    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        pending_d   = pending_q;
        err_code_d  = err_code_q;
        err_state_d = err_state_q;
        count_d     = count_q;

        if (in_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_start) begin
                        type_d      = in_choosen_variable_type;
                        pending_d   = in_active_modules;
                        err_code_d  = 2'd0;
                        err_state_d = 4'd0;
                        case (in_choosen_variable_type)
                            2'b00:   state_d = S_BOOL_PROPOSE;
                            2'b01:   state_d = S_REDUCE;
                            2'b10:   state_d = S_GET_SIZE;
                            default: begin
                                state_d    = S_ERROR;
                                err_code_d = 2'd2;
                            end
                        endcase
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_BOOL_PROPOSE: state_d = S_CHECK;
                S_REDUCE: begin
                    pending_d = reduce_left_s;
                    if (reduce_left_s == '0) begin
                        state_d = S_SELECT_SEGMENT;
                    end else if (timeout_s) begin
                        state_d     = S_ERROR;
                        err_code_d  = 2'd1;
                        err_state_d = state_q;
                    end else begin
                        state_d = S_REDUCE;
                    end
                end
                S_SELECT_SEGMENT: begin
                    if (in_segment_done) begin
                        state_d = S_SAMPLE;
                    end else if (timeout_s) begin
                        state_d     = S_ERROR;
                        err_code_d  = 2'd1;
                        err_state_d = state_q;
                    end else begin
                        state_d = S_SELECT_SEGMENT;
                    end
                end
                S_SAMPLE: begin
                    if (in_sampler_done) begin
                        state_d = S_CHECK;
                    end else if (timeout_s) begin
                        state_d     = S_ERROR;
                        err_code_d  = 2'd1;
                        err_state_d = state_q;
                    end else begin
                        state_d = S_SAMPLE;
                    end
                end
                S_GET_SIZE: begin
                    if (in_discrete_size_valid) begin
                        state_d = S_CHOOSE_VALUE;
                    end else if (timeout_s) begin
                        state_d     = S_ERROR;
                        err_code_d  = 2'd1;
                        err_state_d = state_q;
                    end else begin
                        state_d = S_GET_SIZE;
                    end
                end
                S_CHOOSE_VALUE: state_d = S_READ_VALUE;
                S_READ_VALUE: begin
                    if (in_discrete_value_valid) begin
                        state_d = in_need_sample ? S_SAMPLE : S_CHECK;
                    end else if (timeout_s) begin
                        state_d     = S_ERROR;
                        err_code_d  = 2'd1;
                        err_state_d = state_q;
                    end else begin
                        state_d = S_READ_VALUE;
                    end
                end
                S_CHECK: begin
                    if (in_check_done) begin
                        state_d = S_CALC_PROB;
                    end else if (timeout_s) begin
                        state_d     = S_ERROR;
                        err_code_d  = 2'd1;
                        err_state_d = state_q;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
                S_CALC_PROB: begin
                    state_d = S_IDLE;
                    count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                end
                S_ERROR: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Every state change restarts the per-stage cycle count.
        if (state_d != state_q) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // State registers plus Moore outputs registered from the next state so they align with out_state.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q     <= S_IDLE;
            type_q      <= 2'b00;
            pending_q   <= '0;
            cnt_q       <= 8'd0;
            err_code_q  <= 2'd0;
            err_state_q <= 4'd0;
            count_q     <= '0;
            bool_en_q   <= 1'b0;
            seg_en_q    <= 1'b0;
            size_en_q   <= 1'b0;
            rand_en_q   <= 1'b0;
            table_en_q  <= 1'b0;
            samp_en_q   <= 1'b0;
            comp_en_q   <= 1'b0;
            calc_en_q   <= 1'b0;
            catch_q     <= 1'b0;
            disc_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            red_en_q    <= '0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            err_code_q  <= err_code_d;
            err_state_q <= err_state_d;
            count_q     <= count_d;
            bool_en_q   <= (state_d == S_BOOL_PROPOSE);
            seg_en_q    <= (state_d == S_SELECT_SEGMENT);
            size_en_q   <= (state_d == S_GET_SIZE);
            rand_en_q   <= (state_d == S_CHOOSE_VALUE) || (state_d == S_READ_VALUE);
            table_en_q  <= (state_d == S_READ_VALUE);
            samp_en_q   <= (state_d == S_SAMPLE);
            comp_en_q   <= (state_d == S_CHECK);
            calc_en_q   <= (state_d == S_CALC_PROB);
            catch_q     <= (state_q == S_IDLE) &&
                           ((state_d == S_BOOL_PROPOSE) || (state_d == S_REDUCE) ||
                            (state_d == S_GET_SIZE));
            disc_q      <= (state_d == S_SAMPLE) && (type_d == 2'b10);
            done_q      <= (state_d == S_CALC_PROB);
            error_q     <= (state_d == S_ERROR);
            red_en_q    <= (state_d == S_REDUCE) ? pending_d : '0;
        end
    end

    assign out_state                         = state_q;
    assign out_busy                          = (state_q != S_IDLE);
    assign out_boolean_propose_enable        = bool_en_q;
    assign out_select_segment_enable         = seg_en_q;
    assign out_DiscreteVariablesSizes_enable = size_en_q;
    assign out_random_enable                 = rand_en_q;
    assign out_DiscreteValuesTable_enable    = table_en_q;
    assign out_sampler_enable                = samp_en_q;
    assign out_compute_for_proposed_value    = comp_en_q;
    assign out_calculate_probability_enable  = calc_en_q;
    assign out_catch_U                       = catch_q;
    assign out_reduce_enable                 = red_en_q;
    assign out_chosen_variable_is_discrete   = disc_q;
    assign out_done                          = done_q;
    assign out_error                         = error_q;
    assign out_error_code                    = err_code_q;
    assign out_error_state                   = err_state_q;
    assign out_proposal_count                = count_q;

endmodule
